// File: rtl/pwm_duty_sched.sv
// pwm_duty_sched: drives a registered magnitude comparator (out <= in >= ref)
// with the active duty on cmp_in and a free-running 1..2^WIDTH-1 period
// counter on cmp_ref. Duty writes go to a shadow register and are applied
// only at period boundaries, so every period on pwm_out is whole.
// Optional feature macro: PWM_SOFTSTART_EN (adds a RAMP state that steps the
// active duty up by one per period before entering RUN).
module pwm_duty_sched #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_duty_in,
   input  logic             i_duty_wr,
   output logic             o_duty_pend,
   output logic             o_duty_ack,
   output logic             o_period_end,
   output logic [WIDTH-1:0] o_cmp_in,
   output logic [WIDTH-1:0] o_cmp_ref,
   input  logic             i_cmp_out,
   output logic             o_pwm_out
);

   localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] C_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_RAMP = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_duty_sh;
   logic [WIDTH-1:0] r_duty_act;
   logic             r_pend;
   logic             r_ack;
   logic             r_pe;

   state_t           w_state_nx;
   logic [WIDTH-1:0] w_cnt_nx;
   logic [WIDTH-1:0] w_duty_sh_nx;
   logic [WIDTH-1:0] w_duty_act_nx;
   logic             w_pend_nx;
   logic             w_ack_nx;
   logic             w_pe_nx;
   logic [WIDTH-1:0] w_target;
   logic             w_wrap;
   logic [WIDTH-1:0] w_cnt_inc;

   // A write landing in the same cycle as a transfer wins over the stale shadow.
   always_comb begin
      w_target  = i_duty_wr ? i_duty_in : r_duty_sh;
      w_wrap    = (r_cnt == C_MAX);
      w_cnt_inc = w_wrap ? C_ONE : (r_cnt + C_ONE);
   end

   // State register and all datapath registers, cleared asynchronously.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= C_ONE;
         r_duty_sh  <= '0;
         r_duty_act <= '0;
         r_pend     <= 1'b0;
         r_ack      <= 1'b0;
         r_pe       <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_cnt      <= w_cnt_nx;
         r_duty_sh  <= w_duty_sh_nx;
         r_duty_act <= w_duty_act_nx;
         r_pend     <= w_pend_nx;
         r_ack      <= w_ack_nx;
         r_pe       <= w_pe_nx;
      end
   end

   // Next-state logic: counter, write capture, boundary transfer, enable exits.
   always_comb begin
      w_state_nx    = r_state;
      w_cnt_nx      = r_cnt;
      w_duty_sh_nx  = r_duty_sh;
      w_duty_act_nx = r_duty_act;
      w_pend_nx     = r_pend;
      w_ack_nx      = 1'b0;
      w_pe_nx       = 1'b0;

      if (i_duty_wr) begin
         w_duty_sh_nx = i_duty_in;
         w_pend_nx    = 1'b1;
      end

      case (r_state)
         ST_IDLE: begin
            w_cnt_nx      = C_ONE;
            w_duty_act_nx = '0;
            if (i_en) begin
`ifdef PWM_SOFTSTART_EN
               w_state_nx = ST_RAMP;
`else
               // Counter stays at 1 on the entry edge so the first RUN cycle
               // is the first cycle of a full period.
               w_state_nx    = ST_RUN;
               w_duty_act_nx = w_target;
               if (w_pend_nx) begin
                  w_pend_nx = 1'b0;
                  w_ack_nx  = 1'b1;
               end
`endif
            end
         end

         ST_RUN: begin
            if (!i_en) begin
               w_state_nx    = ST_IDLE;
               w_cnt_nx      = C_ONE;
               w_duty_act_nx = '0;
            end else begin
               w_cnt_nx = w_cnt_inc;
               w_pe_nx  = w_wrap;
               if (w_wrap && w_pend_nx) begin
                  w_duty_act_nx = w_target;
                  w_pend_nx     = 1'b0;
                  w_ack_nx      = 1'b1;
               end
            end
         end

`ifdef PWM_SOFTSTART_EN
         ST_RAMP: begin
            if (!i_en) begin
               w_state_nx    = ST_IDLE;
               w_cnt_nx      = C_ONE;
               w_duty_act_nx = '0;
            end else begin
               w_cnt_nx = w_cnt_inc;
               w_pe_nx  = w_wrap;
               if (w_wrap) begin
                  if (r_duty_act == w_target) begin
                     w_state_nx = ST_RUN;
                     w_pend_nx  = 1'b0;
                     w_ack_nx   = 1'b1;
                  end else if (w_target < r_duty_act) begin
                     w_duty_act_nx = w_target;
                  end else begin
                     w_duty_act_nx = r_duty_act + C_ONE;
                  end
               end
            end
         end
`endif

         default: begin
            w_state_nx    = ST_IDLE;
            w_cnt_nx      = C_ONE;
            w_duty_act_nx = '0;
         end
      endcase
   end

   // Output drive: all registered except the comparator pass-through.
   always_comb begin
      o_cmp_in     = r_duty_act;
      o_cmp_ref    = r_cnt;
      o_duty_pend  = r_pend;
      o_duty_ack   = r_ack;
      o_period_end = r_pe;
      o_pwm_out    = i_cmp_out;
   end

endmodule

// File: tb/tb_pwm_duty_sched.sv
// Directed bench for pwm_duty_sched with a behavioural model of the external
// registered comparator closing the loop from cmp_in/cmp_ref to cmp_out.
module tb_pwm_duty_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic [3:0] duty_in = '0;
   logic       duty_wr = 1'b0;
   logic       duty_pend, duty_ack, period_end, cmp_out, pwm_out;
   logic [3:0] cmp_in, cmp_ref;

   int n_assert = 0;
   int n_fail = 0;
   int ack_total = 0;
   int pe_total = 0;
   bit pend_seen = 0;

   pwm_duty_sched #(.WIDTH(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_duty_in(duty_in),
      .i_duty_wr(duty_wr), .o_duty_pend(duty_pend), .o_duty_ack(duty_ack),
      .o_period_end(period_end), .o_cmp_in(cmp_in), .o_cmp_ref(cmp_ref),
      .i_cmp_out(cmp_out), .o_pwm_out(pwm_out)
   );

   always #5 clk = ~clk;

   // Comparator model: registered, resets low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cmp_out <= 1'b0;
      else     cmp_out <= (cmp_in >= cmp_ref);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (duty_ack === 1'b1) ack_total++;
      if (period_end === 1'b1) pe_total++;
      if (duty_pend === 1'b1) pend_seen = 1;
   endtask

   // Sync to the start of a period on cmp_ref, then count pwm highs across it.
   task automatic run_period(output int hi);
      int n;
      n = 0;
      hi = 0;
      while (cmp_ref !== 4'd1 && n < 40) begin
         step();
         n++;
      end
      check("period_sync", (n < 40), 1);
      for (int i = 0; i < 15; i++) begin
         step();
         if (pwm_out === 1'b1) hi++;
      end
   endtask

   // One period from cnt=1, optionally strobing writes when cmp_ref hits at1/at2.
   task automatic count_window(input int at1, input int v1, input int at2,
                               input int v2, output int hi);
      hi = 0;
      check("window_start", cmp_ref, 1);
      for (int i = 0; i < 15; i++) begin
         duty_wr = 1'b0;
         if (at1 != 0 && int'(cmp_ref) == at1) begin
            duty_wr = 1'b1;
            duty_in = 4'(v1);
         end else if (at2 != 0 && int'(cmp_ref) == at2) begin
            duty_wr = 1'b1;
            duty_in = 4'(v2);
         end
         step();
         if (pwm_out === 1'b1) hi++;
      end
      duty_wr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi, a0, p0, prev;
      int duties[3] = '{1, 7, 15};

      #1 rst = 1'b1;
      #1;
      check("rst_cmp_in", cmp_in, 0);
      check("rst_cmp_ref", cmp_ref, 1);
      check("rst_pend", duty_pend, 0);
      check("rst_ack", duty_ack, 0);
      check("rst_pe", period_end, 0);
      check("rst_pwm", pwm_out, 0);
      step();
      rst = 1'b0;
      step();

`ifdef PWM_SOFTSTART_EN
      duty_in = 4'd4; duty_wr = 1'b1;
      step();
      duty_wr = 1'b0;
      en = 1'b1;
      a0 = ack_total;
      step();
      check("ramp_entry_cmp_in", cmp_in, 0);
      for (int k = 0; k < 5; k++) begin
         run_period(hi);
         check("ramp_period_hi", hi, k);
         if (k == 3) check("ramp_no_early_ack", ack_total - a0, 0);
      end
      check("ramp_ack", ack_total - a0, 1);
      run_period(hi);
      check("ramp_run_hi", hi, 4);
`else
      // Entry with duty 0 via a write made in IDLE.
      duty_in = 4'd0; duty_wr = 1'b1;
      step();
      duty_wr = 1'b0;
      check("idle_pend", duty_pend, 1);
      en = 1'b1;
      a0 = ack_total;
      step();
      check("entry_ack", ack_total - a0, 1);
      check("entry_pend", duty_pend, 0);
      check("entry_cmp_ref", cmp_ref, 1);
      p0 = pe_total;
      run_period(hi);
      check("sweep_hi_0", hi, 0);
      check("sweep_pe_0", pe_total - p0, 1);

      // Duty sweep 1, 7, 15.
      prev = 0;
      foreach (duties[j]) begin
         a0 = ack_total;
         count_window(1, duties[j], 0, 0, hi);
         check("sweep_prev_hi", hi, prev);
         p0 = pe_total;
         run_period(hi);
         check("sweep_hi", hi, duties[j]);
         check("sweep_pe", pe_total - p0, 1);
         check("sweep_ack", ack_total - a0, 1);
         check("sweep_pend", duty_pend, 0);
         prev = duties[j];
      end

      // Boundary update: 4 running, write 12 at cnt=6.
      count_window(1, 4, 0, 0, hi);
      check("bnd_prev_hi", hi, 15);
      run_period(hi);
      check("bnd_duty4_hi", hi, 4);
      a0 = ack_total;
      pend_seen = 0;
      count_window(6, 12, 0, 0, hi);
      check("bnd_cur_hi", hi, 4);
      check("bnd_pend_seen", pend_seen, 1);
      check("bnd_ack", ack_total - a0, 1);
      run_period(hi);
      check("bnd_next_hi", hi, 12);

      // Overwrite: 3 then 10 within one period.
      a0 = ack_total;
      count_window(3, 3, 9, 10, hi);
      check("ovw_cur_hi", hi, 12);
      check("ovw_ack", ack_total - a0, 1);
      run_period(hi);
      check("ovw_next_hi", hi, 10);
      check("ovw_ack_once", ack_total - a0, 1);

      // Write exactly at cnt=15.
      a0 = ack_total;
      pend_seen = 0;
      count_window(15, 5, 0, 0, hi);
      check("sim_cur_hi", hi, 10);
      check("sim_ack", ack_total - a0, 1);
      run_period(hi);
      check("sim_next_hi", hi, 5);
      check("sim_pend_never", pend_seen, 0);

      // Disable at cnt=8 with duty 12, then re-enable.
      count_window(1, 12, 0, 0, hi);
      run_period(hi);
      check("dis_duty12_hi", hi, 12);
      for (int i = 0; i < 7; i++) step();
      check("dis_at_cnt8", cmp_ref, 8);
      en = 1'b0;
      step();
      check("dis_cmp_in", cmp_in, 0);
      check("dis_cmp_ref", cmp_ref, 1);
      step();
      check("dis_pwm_low", pwm_out, 0);
      step();
      check("dis_cnt_held", cmp_ref, 1);
      en = 1'b1;
      a0 = ack_total;
      step();
      check("reen_cmp_ref", cmp_ref, 1);
      check("reen_cmp_in", cmp_in, 12);
      check("reen_no_ack", ack_total - a0, 0);
      step();
      check("reen_cnt2", cmp_ref, 2);
      check("reen_pwm", pwm_out, 1);

      // Reset mid-period with duty 9 running and a write pending.
      duty_in = 4'd9; duty_wr = 1'b1;
      step();
      duty_wr = 1'b0;
      run_period(hi);
      check("rst_pre_hi", hi, 9);
      for (int i = 0; i < 4; i++) step();
      duty_in = 4'd3; duty_wr = 1'b1;
      step();
      duty_wr = 1'b0;
      check("rst_pre_pend", duty_pend, 1);
      check("rst_pre_cmp_in", cmp_in, 9);
      #2;
      rst = 1'b1;
      en = 1'b0;
      #1;
      check("mid_rst_cmp_in", cmp_in, 0);
      check("mid_rst_cmp_ref", cmp_ref, 1);
      check("mid_rst_pend", duty_pend, 0);
      check("mid_rst_pwm", pwm_out, 0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check("post_rst_cmp_in", cmp_in, 0);
      check("post_rst_cmp_ref", cmp_ref, 1);
      check("post_rst_pend", duty_pend, 0);
      check("post_rst_pwm", pwm_out, 0);
      check("post_rst_pe", period_end, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_duty_sched.md
# pwm_duty_sched

Sequencer for the team's registered 4-bit magnitude comparator (`out <= (in >= ref)`). It owns the comparator's `in` and `ref` inputs:
- `in` receives the active duty value.
- `ref` receives a free-running period counter.

The comparator's registered output becomes a PWM waveform. Duty updates arrive through a write/acknowledge handshake and take effect only at period boundaries, so no partial or glitched period is ever produced. The block sits between the control logic (which sets the duty) and the comparator/PWM output stage.

## Interface
- `WIDTH`, 4, comparator operand width. Period is `2^WIDTH-1` cycles.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  run enable. Level-sensitive.
- `duty_in`  in  WIDTH  requested duty, 0 to `2^WIDTH-1`.
- `duty_wr`  in  1  one-cycle strobe; captures `duty_in` into the shadow register.
- `duty_pend`  out  1  shadow value written but not yet applied.
- `duty_ack`  out  1  one-cycle pulse when the shadow value is transferred to active.
- `period_end`  out  1  one-cycle pulse on the last cycle of each period.
- `cmp_in`  out  WIDTH  to comparator `in`; carries the active duty.
- `cmp_ref`  out  WIDTH  to comparator `ref`; carries the period counter.
- `cmp_out`  in  1  registered comparator result.
- `pwm_out`  out  1  PWM output; equals `cmp_out` combinationally.

## Operation
- Registers:
  - `cnt` (WIDTH)
  - `duty_sh` (shadow duty)
  - `duty_act` (active duty)
  - `pend`
  - `ack`
  - `pe`
  - state
- States:
  - IDLE: `cnt` held at 1, `duty_act`=0. Go to RUN when `en`=1.
  - RUN: `cnt` counts 1,2,…,`2^WIDTH-1`, then wraps to 1. Value 0 is never driven. Go to IDLE when `en`=0, immediately on the next edge.
  - RAMP: exists only with `PWM_SOFTSTART_EN`; see Configuration.
- Drive rule: `cmp_in`=`duty_act` and `cmp_ref`=`cnt`. The comparator then yields high for exactly `duty_act` cycles of the 15-cycle period.
  - duty 0 gives constant low.
  - duty 15 gives constant high.
- Write path:
  - `duty_wr`=1 loads `duty_sh` and sets `pend`.
  - Further writes while `pend`=1 overwrite `duty_sh`; the last value wins, and only one ack is issued.
- Transfer: in RUN, on the cycle where `cnt`=`2^WIDTH-1` and `pend`=1:
  - `duty_act` ← `duty_sh`
  - `pend` clears
  - `ack` pulses on the next cycle
- Simultaneous `duty_wr` with a transfer: the incoming value is applied, `pend` stays clear, and `ack` pulses.
- Entering RUN from IDLE: `duty_act` ← `duty_sh` on the entry edge, and `pend` clears with `ack`.
- Leaving RUN: `duty_act` forced to 0, and `cnt` forced to 1. `pend` and `duty_sh` are retained.
- Reset values:
  - `cnt`=1, `duty_act`=0, `duty_sh`=0
  - `pend`=0, `ack`=0, `pe`=0
  - state IDLE
  - Hence `cmp_in`=0, `cmp_ref`=1, `duty_pend`=0, `duty_ack`=0, `period_end`=0.
  - `pwm_out` follows the comparator, which resets low.
- Reset mid-period: all state is cleared asynchronously and any pending write is lost.

## Timing
- `cmp_out` lags `cmp_ref`/`cmp_in` by one cycle, so `pwm_out` lags the counter by one cycle.
- `period_end` is registered. It is high in the cycle after `cnt`=`2^WIDTH-1`, aligned with the first cycle of the new period on `cmp_ref`.
- Worst-case write-to-apply latency is 15 cycles; `duty_ack` follows 1 cycle after that.
- After `en` rises, the first `pwm_out` high appears 2 cycles later (state entry, then comparator register).
- After `en` falls, `pwm_out` is low within 2 cycles.

## Configuration
- Macro: `PWM_SOFTSTART_EN`.
- Defined:
  - IDLE→RUN passes through RAMP. `duty_act` starts at 0 and increments by 1 at each period end until it equals `duty_sh`, then the block enters RUN and pulses `duty_ack`.
  - Writes during RAMP retarget the ramp. If the new target is below `duty_act`, `duty_act` jumps to the target immediately at the next period end.
  - `en`=0 in RAMP returns to IDLE.
- Undefined: the RAMP state is absent. Entry loads `duty_sh` directly, as described in Operation.

## Test plan
- Reset: assert `rst` mid-period with `duty_act`=9. Outputs `cmp_in`=0, `cmp_ref`=1, `duty_pend`=0 and `pwm_out`=0 immediately; remain so after release while `en`=0.
- Duty sweep: `en`=1 with duties 0, 1, 7, 15. `pwm_out` is high 0, 1, 7 and 15 of every 15 cycles; `period_end` pulses every 15 cycles.
- Boundary update: run at duty 4 and write 12 at `cnt`=6. The current period stays at 4 high; `duty_ack` pulses once; the next period is 12 high.
- Overwrite and simultaneity:
  - Write 3 then 10 within one period: a single ack, and 10 is applied.
  - Write 5 exactly at `cnt`=15: applied next period, `pend` never seen high afterward.
- Disable mid-period: drop `en` at `cnt`=8 with duty 12. `pwm_out` is low within 2 cycles. Re-enable: the counter restarts at 1.
- `PWM_SOFTSTART_EN` build: `duty_sh`=4, then `en`=1. Periods show 0, 1, 2, 3, 4 high cycles, then `duty_ack` pulses.
